dbu_ctrl: RTL and testbench
===========================

// Module: dbu_ctrl
// PURPOSE
//  Debug unit for the pipelined CPU. It sits between the board buttons/switches and the CPU debug port.
//  - Gates CPU progress through a clock-enable: continuous run or single step.
//  - Drives the CPU debug selects (m_rf_addr, i_sel).
//  - Registers the CPU debug read data (m_data, rf_data, o_sel_data, status) for the display and LEDs.
// PARAMETERS
//  DEBOUNCE_CYCLES  16    consecutive stable cycles before a filtered button level changes
//  MEM_BYTES        1024  data-memory byte span; the memory address wraps inside it (power of 2)
//  RF_DEPTH         32    register-file entries; the RF address wraps inside it (power of 2)
// PORTS
//  clk         in   1   system clock, rising edge
//  rst         in   1   synchronous reset, active-high
//  succ        in   1   switch: 1 = continuous run
//  step        in   1   button: single step
//  inc         in   1   button: next debug address
//  dec         in   1   button: previous debug address
//  m_rf        in   1   switch: 1 = view data memory, 0 = view register file
//  sel         in   3   switch: 0 = mem/RF view, 1..7 = CPU internal view
//  run         out  1   CPU clock-enable
//  m_rf_addr   out  16  debug address to CPU (byte address in mem view, index in RF view)
//  i_sel       out  3   internal-view select to CPU
//  m_data      in   32  CPU data-memory debug read
//  rf_data     in   32  CPU register-file debug read
//  o_sel_data  in   32  CPU internal-view data
//  status      in   16  CPU control status
//  disp_data   out  32  registered value for the 7-segment display
//  led         out  16  registered LED value
// BEHAVIOUR
//  - Reset: run=0, m_rf_addr=0, i_sel=0, disp_data=0, led=0, FSM=IDLE, debounce counters=0.
//  - Button conditioning (step, inc, dec):
//    - 2-FF synchroniser, then debounce counter; the filtered level takes the synced level only after
//      DEBOUNCE_CYCLES consecutive equal samples; any mismatch clears the counter.
//    - Rising edge of the filtered level gives a 1-cycle pulse.
//    - Worst-case press-to-pulse latency = 2 + DEBOUNCE_CYCLES + 1 cycles.
//  - succ and m_rf: 2-FF synchroniser only.
//  - FSM:
//    - IDLE: run=0.
//      - succ=1 -> RUN.
//      - Otherwise a step pulse -> STEP.
//    - RUN: run=1 every cycle; succ=0 -> IDLE.
//    - STEP: run=1 for exactly one cycle, then -> WAIT.
//    - WAIT: run=0; leaves to IDLE once filtered step=0. A held button gives exactly one CPU cycle.
//    - succ takes priority over step in IDLE. succ rising while in STEP/WAIT is honoured only after
//      returning to IDLE.
//  - Address counter (only when sel==0):
//    - inc pulse: +4 in mem view, +1 in RF view; dec pulse: the matching decrement.
//    - Mem view wraps MEM_BYTES-4 <-> 0; RF view wraps RF_DEPTH-1 <-> 0.
//    - inc and dec pulses in the same cycle: no change.
//    - Any change of synced m_rf clears m_rf_addr to 0 on the next cycle; this beats inc/dec in that cycle.
//    - Bits [1:0] are always 0 in mem view. Upper unused bits are always 0.
//  - Display (1-cycle registered latency from the CPU read data):
//    - sel==0: i_sel=0; disp_data = m_rf ? m_data : rf_data; led = m_rf_addr.
//    - sel!=0: i_sel=sel; disp_data = o_sel_data; led = status.
//  - Reset mid-step or mid-run: run drops on the next clk edge; a pending debounce is discarded.
// CONFIGURATION
//  Macro DBU_BREAKPOINT_EN.
//  - Defined: adds ports pc_in (in, 32, current CPU PC), bp_addr (in, 32) and bp_valid (in, 1),
//    and an FSM state HALT.
//    - In RUN, if bp_valid=1 and pc_in==bp_addr: run=0 that same cycle (combinational) -> HALT.
//    - HALT: run=0; leaves to IDLE when succ=0. A step from IDLE then advances past the breakpoint.
//    - In sel==0, led[15] = 1 while in HALT.
//  - Undefined: none of these ports exist; no HALT state; led as above.
// TESTING
//  - Reset: rst=1 for 2 cycles -> run=0, m_rf_addr=0, disp_data=0, led=0.
//  - Step: hold step for 50 cycles with DEBOUNCE_CYCLES=16 -> run high for exactly 1 cycle,
//    about 19 cycles after the press; no further run until release and a new press.
//  - Bounce: toggle step every 5 cycles for 40 cycles, then release -> run never asserts.
//  - Address: m_rf=1; dec once -> m_rf_addr=0x3FC; inc twice -> 0x004.
//    Switch m_rf to 0 -> addr 0; dec -> 31.
//  - View: sel=3, o_sel_data=0xDEADBEEF, status=0x00A5 -> i_sel=3; one cycle later
//    disp_data=0xDEADBEEF, led=0x00A5. inc pulse -> m_rf_addr unchanged.
//  - Breakpoint (DBU_BREAKPOINT_EN): bp_addr=0x10, bp_valid=1, succ=1, pc_in counts by 4 ->
//    run=0 in the cycle pc_in=0x10, FSM in HALT; succ=0 then a step -> one run pulse.

Source files
------------

// File: rtl/dbu_ctrl.sv
// -----------------------------------------------------------------------------
// dbu_ctrl - debug unit between the board buttons/switches and the CPU debug port.
//
// Gates CPU progress through a clock-enable (continuous run or single step),
// drives the CPU debug selects and registers the CPU debug read data for the
// 7-segment display and the LEDs.
//
// Ports
//   clk, rst        system clock (rising edge), synchronous active-high reset
//   succ            switch, 1 = continuous run
//   step/inc/dec    buttons: single step, next / previous debug address
//   m_rf            switch, 1 = data-memory view, 0 = register-file view
//   sel[2:0]        switch, 0 = mem/RF view, 1..7 = CPU internal view
//   run             CPU clock-enable
//   m_rf_addr[15:0] debug address (byte address in mem view, index in RF view)
//   i_sel[2:0]      internal-view select to the CPU
//   m_data, rf_data, o_sel_data [31:0], status[15:0]   CPU debug read data
//   disp_data[31:0] registered display value
//   led[15:0]       registered LED value
//
// Optional feature, macro DBU_BREAKPOINT_EN:
//   adds pc_in[31:0], bp_addr[31:0], bp_valid and a HALT state. A PC match while
//   running drops run in the same cycle and parks the FSM in HALT; led[15]
//   flags HALT in the mem/RF view.
// -----------------------------------------------------------------------------
module dbu_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MEM_BYTES       = 1024,
    parameter int RF_DEPTH        = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        succ,
    input  logic        step,
    input  logic        inc,
    input  logic        dec,
    input  logic        m_rf,
    input  logic [2:0]  sel,
    output logic        run,
    output logic [15:0] m_rf_addr,
    output logic [2:0]  i_sel,
    input  logic [31:0] m_data,
    input  logic [31:0] rf_data,
    input  logic [31:0] o_sel_data,
    input  logic [15:0] status,
`ifdef DBU_BREAKPOINT_EN
    input  logic [31:0] pc_in,
    input  logic [31:0] bp_addr,
    input  logic        bp_valid,
`endif
    output logic [31:0] disp_data,
    output logic [15:0] led
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    // Byte addresses stay word aligned, so the mem mask also clears bits [1:0].
    localparam logic [15:0] MEM_MASK = 16'(MEM_BYTES - 1) & 16'hFFFC;
    localparam logic [15:0] RF_MASK  = 16'(RF_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
`ifdef DBU_BREAKPOINT_EN
        S_WAIT = 3'd3,
        S_HALT = 3'd4
`else
        S_WAIT = 3'd3
`endif
    } state_t;

    // Button bit order: [0] step, [1] inc, [2] dec.
    logic [2:0]       btn_s1_q, btn_s2_q;
    logic [2:0]       filt_q, filt_d, filt_prev_q;
    logic [2:0]       pulse_s;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    // Switch bit order: [0] succ, [1] m_rf.
    logic [1:0]       sw_s1_q, sw_s2_q;
    logic             m_rf_prev_q;
    logic             succ_s, m_rf_s, m_rf_chg_s;

    state_t           state_q, state_d;
    logic             run_s;
    logic [15:0]      addr_q, addr_d;
    logic [2:0]       i_sel_q, i_sel_d;
    logic [31:0]      disp_q, disp_d;
    logic [15:0]      led_q, led_d;

    assign succ_s     = sw_s2_q[0];
    assign m_rf_s     = sw_s2_q[1];
    assign m_rf_chg_s = m_rf_s ^ m_rf_prev_q;
    assign pulse_s    = filt_q & ~filt_prev_q;

    // Input synchronisers, debounce state and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_q    <= 3'b000;
            btn_s2_q    <= 3'b000;
            filt_q      <= 3'b000;
            filt_prev_q <= 3'b000;
            sw_s1_q     <= 2'b00;
            sw_s2_q     <= 2'b00;
            m_rf_prev_q <= 1'b0;
            for (int b = 0; b < 3; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            btn_s1_q    <= {dec, inc, step};
            btn_s2_q    <= btn_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            sw_s1_q     <= {m_rf, succ};
            sw_s2_q     <= sw_s1_q;
            m_rf_prev_q <= m_rf_s;
            for (int b = 0; b < 3; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
        end
    end

    // Debounce: count consecutive samples that disagree with the filtered level.
    always_comb begin
        filt_d = filt_q;
        for (int b = 0; b < 3; b++) begin
            cnt_d[b] = '0;
            if (btn_s2_q[b] != filt_q[b]) begin
                if (cnt_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[b] = btn_s2_q[b];
                    cnt_d[b]  = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + CNT_W'(1);
                end
            end else begin
                cnt_d[b] = '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and CPU clock-enable.
    always_comb begin
        state_d = state_q;
        run_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (succ_s) begin
                    state_d = S_RUN;
                end else if (pulse_s[0]) begin
                    state_d = S_STEP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                run_s = 1'b1;
`ifdef DBU_BREAKPOINT_EN
                if (bp_valid && (pc_in == bp_addr)) begin
                    run_s   = 1'b0;
                    state_d = S_HALT;
                end else if (!succ_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
`else
                if (!succ_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
`endif
            end
            S_STEP: begin
                run_s   = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Held button: stay here until the filtered level falls.
                if (!filt_q[0]) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
`ifdef DBU_BREAKPOINT_EN
            S_HALT: begin
                if (!succ_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HALT;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Debug address: a view change wins over inc/dec; coincident inc+dec cancel.
    always_comb begin
        addr_d = addr_q;
        if (m_rf_chg_s) begin
            addr_d = 16'd0;
        end else if ((sel == 3'd0) && (pulse_s[1] != pulse_s[2])) begin
            if (pulse_s[1]) begin
                addr_d = m_rf_s ? ((addr_q + 16'd4) & MEM_MASK) : ((addr_q + 16'd1) & RF_MASK);
            end else begin
                addr_d = m_rf_s ? ((addr_q - 16'd4) & MEM_MASK) : ((addr_q - 16'd1) & RF_MASK);
            end
        end else begin
            addr_d = addr_q;
        end
    end

    // Display and LED selection.
    always_comb begin
        i_sel_d = 3'd0;
        disp_d  = 32'd0;
        led_d   = 16'd0;
        if (sel == 3'd0) begin
            i_sel_d = 3'd0;
            disp_d  = m_rf_s ? m_data : rf_data;
`ifdef DBU_BREAKPOINT_EN
            led_d   = {addr_q[15] | (state_q == S_HALT), addr_q[14:0]};
`else
            led_d   = addr_q;
`endif
        end else begin
            i_sel_d = sel;
            disp_d  = o_sel_data;
            led_d   = status;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= 16'd0;
            i_sel_q <= 3'd0;
            disp_q  <= 32'd0;
            led_q   <= 16'd0;
        end else begin
            addr_q  <= addr_d;
            i_sel_q <= i_sel_d;
            disp_q  <= disp_d;
            led_q   <= led_d;
        end
    end

    assign run       = run_s;
    assign m_rf_addr = addr_q;
    assign i_sel     = i_sel_q;
    assign disp_data = disp_q;
    assign led       = led_q;

endmodule

// File: tb/tb_dbu_ctrl.sv
// Testbench for dbu_ctrl: directed scenarios followed by randomized button,
// switch and view traffic checked against a behavioural model of the debug unit.
module tb_dbu_ctrl;

    logic        clk = 1'b0;
    logic        rst, succ, step, inc, dec, m_rf;
    logic [2:0]  sel;
    logic        run;
    logic [15:0] m_rf_addr;
    logic [2:0]  i_sel;
    logic [31:0] m_data, rf_data, o_sel_data;
    logic [15:0] status;
    logic [31:0] disp_data;
    logic [15:0] led;
`ifdef DBU_BREAKPOINT_EN
    logic [31:0] pc_in;
    logic [31:0] bp_addr;
    logic        bp_valid;
`endif

    int checks    = 0;
    int failures  = 0;
    int run_total = 0;

    dbu_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .succ       (succ),
        .step       (step),
        .inc        (inc),
        .dec        (dec),
        .m_rf       (m_rf),
        .sel        (sel),
        .run        (run),
        .m_rf_addr  (m_rf_addr),
        .i_sel      (i_sel),
        .m_data     (m_data),
        .rf_data    (rf_data),
        .o_sel_data (o_sel_data),
        .status     (status),
`ifdef DBU_BREAKPOINT_EN
        .pc_in      (pc_in),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
`endif
        .disp_data  (disp_data),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Count CPU-enabled cycles, sampled away from the active edge.
    always @(negedge clk) begin
        if (run === 1'b1) run_total++;
    end

`ifdef DBU_BREAKPOINT_EN
    // Minimal CPU: PC advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (rst) pc_in <= 32'd0;
        else if (run) pc_in <= pc_in + 32'd4;
    end
`endif

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int btn, input logic v);
        case (btn)
            0: step = v;
            1: inc  = v;
            2: dec  = v;
            3: begin inc = v; dec = v; end
            default: ;
        endcase
    endtask

    task automatic press(input int btn, input int hold, input int gap);
        set_btn(btn, 1'b1);
        cyc(hold);
        set_btn(btn, 1'b0);
        cyc(gap);
    endtask

    initial begin
        int lat, r0, act, hold, gap, n, exp_run, m_addr;
        bit long_p, m_view;
        logic [31:0] exp_disp;
        logic [15:0] exp_led;

        rst = 1'b1; succ = 1'b0; step = 1'b0; inc = 1'b0; dec = 1'b0; m_rf = 1'b0;
        sel = 3'd0; m_data = 32'h1111_2222; rf_data = 32'h3333_4444;
        o_sel_data = 32'h5555_6666; status = 16'h7777;
`ifdef DBU_BREAKPOINT_EN
        bp_addr = 32'h10; bp_valid = 1'b0;
`endif
        // Reset for two cycles.
        cyc(2);
        check("rst_run", run, 32'd0);
        check("rst_addr", m_rf_addr, 32'd0);
        check("rst_isel", i_sel, 32'd0);
        check("rst_disp", disp_data, 32'd0);
        check("rst_led", led, 32'd0);
        rst = 1'b0;
        cyc(3);

        // Held step: one CPU cycle after sync + debounce + FSM latency.
        r0 = run_total;
        step = 1'b1;
        lat = 61;
        for (int i = 1; i <= 60; i++) begin
            cyc(1);
            if (run === 1'b1) begin
                lat = i;
                break;
            end
        end
        check("step_latency", lat, 32'd19);
        if (lat < 50) cyc(50 - lat);
        step = 1'b0;
        cyc(25);
        check("step_once", run_total - r0, 32'd1);

        // Bouncing step never reaches the debounce threshold.
        r0 = run_total;
        for (int i = 0; i < 8; i++) begin
            step = ~step;
            cyc(5);
        end
        step = 1'b0;
        cyc(30);
        check("bounce_no_run", run_total - r0, 32'd0);

        // Address counter with wrap in both views.
        m_rf = 1'b1;
        cyc(5);
        check("mem_view_addr0", m_rf_addr, 32'd0);
        press(2, 20, 22);
        check("mem_dec_wrap", m_rf_addr, 32'h3FC);
        press(1, 20, 22);
        press(1, 20, 22);
        check("mem_inc_wrap", m_rf_addr, 32'h004);
        m_rf = 1'b0;
        cyc(5);
        check("view_change_clr", m_rf_addr, 32'd0);
        press(2, 20, 22);
        check("rf_dec_wrap", m_rf_addr, 32'd31);
        press(3, 20, 22);
        check("inc_dec_cancel", m_rf_addr, 32'd31);
        check("led_addr", led, 32'd31);

        // Internal view.
        sel = 3'd3; o_sel_data = 32'hDEADBEEF; status = 16'h00A5;
        cyc(2);
        check("view_isel", i_sel, 32'd3);
        check("view_disp", disp_data, 32'hDEADBEEF);
        check("view_led", led, 32'h00A5);
        press(1, 20, 22);
        check("view_inc_ignored", m_rf_addr, 32'd31);
        sel = 3'd0;

        // Continuous run for exactly the synced duration of succ.
        r0 = run_total;
        succ = 1'b1;
        cyc(12);
        succ = 1'b0;
        cyc(6);
        check("succ_run_len", run_total - r0, 32'd12);

        // Reset in the middle of a run.
        succ = 1'b1;
        cyc(5);
        check("run_high", run, 32'd1);
        rst = 1'b1;
        cyc(1);
        check("rst_mid_run", run, 32'd0);
        check("rst_mid_addr", m_rf_addr, 32'd0);
        succ = 1'b0;
        cyc(1);
        rst = 1'b0;
        cyc(3);

        // Reset discards a partly debounced press.
        r0 = run_total;
        step = 1'b1;
        cyc(10);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(10);
        step = 1'b0;
        cyc(25);
        check("rst_discard_press", run_total - r0, 32'd0);

        // Randomized traffic against the behavioural model.
        m_addr = 0;
        m_view = 1'b0;
        for (int it = 0; it < 25; it++) begin
            act    = $urandom_range(0, 4);
            sel    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            long_p = 1'($urandom_range(0, 1));
            hold   = long_p ? $urandom_range(20, 30) : $urandom_range(2, 12);
            gap    = $urandom_range(22, 30);
            r0     = run_total;
            exp_run = 0;
            case (act)
                0: begin
                    press(1, hold, gap);
                    if (long_p && sel == 3'd0)
                        m_addr = m_view ? (m_addr + 4) % 1024 : (m_addr + 1) % 32;
                end
                1: begin
                    press(2, hold, gap);
                    if (long_p && sel == 3'd0)
                        m_addr = m_view ? (m_addr + 1020) % 1024 : (m_addr + 31) % 32;
                end
                2: begin
                    press(0, hold, gap);
                    exp_run = long_p ? 1 : 0;
                end
                3: begin
                    m_rf = ~m_rf;
                    m_view = ~m_view;
                    cyc(gap);
                    m_addr = 0;
                end
                default: begin
                    n = $urandom_range(3, 30);
                    succ = 1'b1;
                    cyc(n);
                    succ = 1'b0;
                    cyc(gap);
                    exp_run = n;
                end
            endcase
            check("rand_addr", m_rf_addr, 32'(m_addr));
            check("rand_run", run_total - r0, 32'(exp_run));
            m_data = $urandom; rf_data = $urandom; o_sel_data = $urandom;
            status = 16'($urandom);
            cyc(2);
            if (sel == 3'd0) begin
                exp_disp = m_view ? m_data : rf_data;
                exp_led  = 16'(m_addr);
            end else begin
                exp_disp = o_sel_data;
                exp_led  = status;
            end
            check("rand_disp", disp_data, exp_disp);
            check("rand_led", led, {16'd0, exp_led});
            check("rand_isel", i_sel, {29'd0, sel});
        end
        sel = 3'd0;

`ifdef DBU_BREAKPOINT_EN
        // Breakpoint halts the run in the matching cycle; a step moves past it.
        m_rf = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bp_valid = 1'b1;
        succ = 1'b1;
        lat = 41;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (pc_in == 32'h10) begin
                lat = i;
                break;
            end
        end
        check("bp_reached", (lat < 40) ? 32'd1 : 32'd0, 32'd1);
        check("bp_run_drop", run, 32'd0);
        cyc(3);
        check("bp_pc_held", pc_in, 32'h10);
        check("bp_halt_run", run, 32'd0);
        check("bp_halt_led", led, 32'h8000);
        succ = 1'b0;
        cyc(5);
        r0 = run_total;
        press(0, 20, 25);
        check("bp_step_once", run_total - r0, 32'd1);
        check("bp_step_pc", pc_in, 32'h14);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
